fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Generates the sequential PC and issues single-beat AXI4 read requests to instruction memory.
- Buffers returned words in a small FIFO and presents instF/PCF/validF to IF/ID.
- Handles hazard stalls and branch/jump redirects; in-flight responses made stale by a redirect are discarded.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;
    localparam logic [31:0] RV_NOP         = 32'h0000_0013;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a combinational head; DEPTH must be a power of 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may accept a push in the same cycle it pops.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, single-beat AXI4 reads, instruction buffer, redirect/stall.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
//   state   | meaning
//   AR_IDLE | no address in flight on AR; issue when credit allows
//   AR_WAIT | m_arvalid held with a fixed m_araddr until m_arready
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          AXI_ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallF,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         instF,
    output logic [31:0]         PCF,
    output logic                validF,
    output logic                faultF,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [31:0]         m_araddr,
    output logic [AXI_ID_W-1:0] m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [31:0]         m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);
    localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

    ar_state_t        state;
    ar_state_t        state_next;
    logic [31:0]      pc_req;
    logic [31:0]      ar_addr;
    logic [31:0]      last_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] tag_count;
    logic             ar_stale;
    logic             credit;
    logic             issue;
    logic             ar_hs;
    logic             resp_keep;
    logic             pop;
    fetch_entry_t     inst_head;
    fetch_entry_t     inst_din;
    logic [31:0]      tag_head;
    logic             inst_full;
    logic             inst_empty;
    logic             tag_full;
    logic             tag_empty;
    logic             unused_sigs;

    assign ar_hs            = (state == AR_WAIT) && m_arready;
    assign credit           = ({1'b0, outstanding} + {1'b0, inst_count}) < DEPTH_V;
    assign issue            = (state == AR_IDLE) && credit && !redirect;
    assign resp_keep        = m_rvalid && (drop_cnt == '0) && !redirect;
    assign pop              = validF && !stallF && !redirect;
    assign outstanding_next = outstanding + CNT_W'(ar_hs) - CNT_W'(m_rvalid);

    always_ff @(posedge clk) begin
        if (rst) state <= AR_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        m_arvalid  = 1'b0;
        case (state)
            AR_IDLE: if (issue) state_next = AR_WAIT;
            AR_WAIT: begin
                m_arvalid = 1'b1;
                if (m_arready) state_next = AR_IDLE;
            end
            default: state_next = AR_IDLE;
        endcase
    end

    // ar_stale marks an AR that must still complete at its old address after a redirect;
    // its response is already counted in drop_cnt and it gets no PC tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_req      <= RESET_PC;
            ar_addr     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            ar_stale    <= 1'b0;
            last_pc     <= '0;
        end else begin
            outstanding <= outstanding_next;
            last_pc     <= PCF;
            if (issue) ar_addr <= pc_req;
            if (redirect) begin
                pc_req   <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= outstanding_next + CNT_W'((state == AR_WAIT) && !m_arready);
                ar_stale <= (state == AR_WAIT) && !m_arready;
            end else begin
                if (ar_hs && !ar_stale) pc_req <= pc_req + 32'd4;
                if (ar_hs) ar_stale <= 1'b0;
                if (m_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ar_hs && !ar_stale),
        .pop   (resp_keep),
        .flush (redirect),
        .din   (ar_addr),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    assign inst_din = '{inst: m_rdata, pc: tag_head, fault: (m_rresp != AXI_RESP_OKAY)};

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .pop   (pop),
        .flush (redirect),
        .din   (inst_din),
        .head  (inst_head),
        .full  (inst_full),
        .empty (inst_empty),
        .count (inst_count)
    );

    assign validF    = !inst_empty;
    assign instF     = inst_empty ? RV_NOP  : inst_head.inst;
    assign PCF       = inst_empty ? last_pc : inst_head.pc;
    assign faultF    = inst_empty ? 1'b0    : inst_head.fault;

    assign m_araddr  = ar_addr;
    assign m_arid    = '0;
    assign m_arlen   = 8'd0;
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;
    assign m_rready  = 1'b1;

    assign unused_sigs = ^{m_rlast, redirect_pc[1:0], inst_full, tag_full, tag_empty, tag_count};

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)              perf_fetched <= perf_fetched + 32'd1;
            if (stallF && validF) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: AXI slave model, expected-stream scoreboard and monitor.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instF, PCF;
    logic        validF, faultF;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .AXI_ID_W(4)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirect_pc(redirect_pc),
        .instF(instF), .PCF(PCF), .validF(validF), .faultF(faultF),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_next_pc = RESET_PC;

    logic [31:0] rsp_addr_q[$];
    int          rsp_time_q[$];
    int          cyc = 0;
    int          ar_mode = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          slave_out = 0;
    logic        prev_ar_wait = 1'b0;
    logic [31:0] prev_araddr = '0;
    logic        exp_ar_en = 1'b0;
    int          exp_ar_skip = 0;
    logic [31:0] exp_ar_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5679;
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return a[6:2] == 5'd2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc    = exp_next_pc;
            e.inst  = mem_word(exp_next_pc);
            e.fault = is_fault(exp_next_pc);
            exp_q.push_back(e);
            exp_next_pc = exp_next_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_next_pc = {pc[31:2], 2'b00};
        top_up();
    endtask

    task automatic tick();
        @(negedge clk);
        top_up();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs();
        chk("rst_validF", validF, 0);
        chk("rst_instF", instF, NOP);
        chk("rst_PCF", PCF, 0);
        chk("rst_faultF", faultF, 0);
        chk("rst_arvalid", m_arvalid, 0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        tick();
        redirect    = 1'b1;
        redirect_pc = target;
        restart_stream(target);
        tick();
        redirect = 1'b0;
    endtask

    // AXI slave: in-order responses, configurable arready and latency.
    always begin
        @(negedge clk);
        cyc++;
        m_arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rsp_addr_q.size() > 0 && rsp_time_q[0] <= cyc) begin
            m_rvalid = 1'b1;
            m_rdata  = mem_word(rsp_addr_q[0]);
            m_rresp  = is_fault(rsp_addr_q[0]) ? 2'b10 : 2'b00;
        end else begin
            m_rvalid = 1'b0;
            m_rdata  = $urandom;
            m_rresp  = 2'b00;
        end
        #2;
        if (rst) begin
            rsp_addr_q.delete();
            rsp_time_q.delete();
            slave_out    = 0;
            prev_ar_wait = 1'b0;
        end else begin
            if (prev_ar_wait) begin
                chk("ar_hold_valid", m_arvalid, 1);
                chk("ar_hold_addr", m_araddr, prev_araddr);
            end
            prev_ar_wait = m_arvalid && !m_arready;
            prev_araddr  = m_araddr;
            if (m_rvalid) begin
                chk("rready", m_rready, 1);
                void'(rsp_addr_q.pop_front());
                void'(rsp_time_q.pop_front());
                slave_out--;
            end
            if (m_arvalid && m_arready) begin
                slave_out++;
                chk("outstanding_le_depth", slave_out <= DEPTH, 1);
                chk("ar_fields", {m_arid, m_arlen, m_arsize, m_arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
                rsp_addr_q.push_back(m_araddr);
                rsp_time_q.push_back(cyc + 1 + int'($urandom_range(lat_min, lat_max)));
                if (exp_ar_en) begin
                    if (exp_ar_skip > 0) exp_ar_skip--;
                    else begin
                        chk("ar_addr_after_event", m_araddr, exp_ar_addr);
                        exp_ar_en = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares the presented entry with the scoreboard head, pops on consume.
    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b0 && !redirect) begin
            if (validF === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: validF=1 PCF=%h with no expected entry", PCF);
                end else begin
                    chk("PCF", PCF, exp_q[0].pc);
                    chk("instF", instF, exp_q[0].inst);
                    chk("faultF", faultF, exp_q[0].fault);
                    if (!stallF) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end else begin
                chk("idle_instF", instF, NOP);
                chk("idle_faultF", faultF, 0);
            end
        end
    end

    initial begin
        logic found;
        restart_stream(RESET_PC);
        run(2);
        rst         = 1'b0;
        exp_ar_en   = 1'b1;
        exp_ar_skip = 0;
        exp_ar_addr = RESET_PC;
        #2;
        check_reset_outputs();

        // Free-running memory, 1-cycle response, covers the faulting word at PC 8.
        run(40);

        // Stall until the buffer fills, then hold for 5 cycles.
        stallF = 1'b1;
        run(8);
        for (int i = 0; i < 5; i++) begin
            tick();
            #2;
            chk("stall_validF", validF, 1);
            chk("stall_no_ar", m_arvalid, 0);
        end
        tick();
        stallF = 1'b0;
        run(20);

        // Redirect with long-latency reads in flight.
        lat_min = 5;
        lat_max = 5;
        run(12);
        do_redirect(32'h0000_0100);
        run(30);
        lat_min = 0;
        lat_max = 0;
        run(10);

        // Redirect while an AR is held off by arready=0.
        ar_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            #2;
            if (m_arvalid) found = 1'b1;
        end
        chk("ar_pending_seen", found, 1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        restart_stream(32'h0000_0103);
        exp_ar_en   = 1'b1;
        exp_ar_skip = 1;
        exp_ar_addr = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        run(2);
        ar_mode = 0;
        run(30);
        chk("ar_after_redirect_seen", exp_ar_en, 0);

        // PC wraps across 2^32.
        do_redirect(32'hFFFF_FFF8);
        run(20);

        // Randomized traffic.
        ar_mode = 1;
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            tick();
            stallF   = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 39) == 0);
            if (redirect) begin
                redirect_pc = $urandom;
                restart_stream(redirect_pc);
            end
        end
        tick();
        redirect = 1'b0;
        stallF   = 1'b0;
        run(10);

        // One-cycle reset in the middle of fetching.
        tick();
        rst = 1'b1;
        restart_stream(RESET_PC);
        exp_ar_en   = 1'b1;
        exp_ar_skip = 0;
        exp_ar_addr = RESET_PC;
        tick();
        rst = 1'b0;
        #2;
        check_reset_outputs();
        ar_mode = 0;
        lat_max = 0;
        run(30);
        chk("ar_after_reset_seen", exp_ar_en, 0);
        chk("enough_pops", pops > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
